dst_fetch: RTL and testbench
============================

DST_FETCH -- requirements
Module: dst_fetch

Interface
REQ-001 Parameter: ADDR_W, default 20, memory address width.
REQ-002 Parameter: TO_CYCLES, default 15, maximum wait cycles for MRDY before abort.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 Port: CLK  in  1  system clock, all state changes on its rising edge.
REQ-005 Port: RESET  in  1  synchronous active-high reset.
REQ-006 Port: DSTREQ  in  1  blitter request to fetch one destination byte.
REQ-007 Port: DSTADDR  in  ADDR_W  destination byte address, sampled with DSTREQ.
REQ-008 Port: MREQ  out  1  memory bus read request.
REQ-009 Port: MADDR  out  ADDR_W  read address, valid while MREQ=1.
REQ-010 Port: MGNT  in  1  bus grant from arbiter.
REQ-011 Port: MRDY  in  1  memory data valid strobe.
REQ-012 Port: MD  in  8  memory read data.
REQ-013 Port: ID  out  8  byte driven onto the internal data bus.
REQ-014 Port: IDEN  out  1  internal-bus drive enable for ID.
REQ-015 Port: LDDSTL  out  1  active-low load strobe to the destination data register.
REQ-016 Port: DSTACK  out  1  one-cycle completion pulse.
REQ-017 Port: BUSY  out  1  high in every state except IDLE.
REQ-018 Port: ERR  out  1  sticky timeout flag.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT, DRIVE, LOAD, HOLD, DONE.
REQ-020 In IDLE, DSTREQ=1 SHALL capture DSTADDR into MADDR, clear ERR, and go to REQ.
REQ-021 REQ: MREQ=1; MGNT=1 SHALL go to WAIT. Without MGNT, stay in REQ with no limit.
REQ-022 WAIT: MREQ=1 held. Once in WAIT, MGNT SHALL be ignored.
REQ-023 WAIT: MRDY=1 SHALL capture MD into the data register and go to DRIVE. MREQ=0 from DRIVE onward.
REQ-024 MRDY SHALL be ignored in every state except WAIT.
REQ-025 DRIVE/LOAD/HOLD: IDEN=1 and ID=captured byte. LDDSTL=0 only in LOAD, otherwise 1. This gives one cycle of setup and one of hold around the load strobe.
REQ-026 DONE: DSTACK=1 for exactly one cycle, then go to IDLE.
REQ-027 Latency SHALL be fixed when MGNT=1 on the first REQ cycle and MRDY=1 on the first WAIT cycle:
- DSTREQ sampled at edge n.
- MREQ high during n+1 and n+2.
- LDDSTL low during n+4.
- DSTACK high during n+6.
- BUSY low again from n+7.
REQ-028 The wait counter SHALL reset on entry to WAIT and increment each WAIT cycle without MRDY.
REQ-029 Reaching TO_CYCLES SHALL set ERR=1, drop MREQ, skip DRIVE/LOAD/HOLD (LDDSTL stays 1, IDEN stays 0), and go to DONE.
REQ-030 MRDY on the same cycle the counter reaches TO_CYCLES SHALL win: complete normally, no ERR.
REQ-031 DSTREQ while BUSY=1 SHALL be ignored and not queued.
REQ-032 DSTREQ high in the DONE cycle SHALL be ignored. A new fetch starts only from IDLE.
REQ-033 ERR SHALL remain set until the next accepted DSTREQ or RESET.
REQ-034 When IDEN=0, ID SHALL be 8'h00.

Reset
REQ-035 RESET=1 at any edge SHALL force IDLE regardless of state, including mid-fetch.
REQ-036 Reset values: MREQ=0, MADDR=0, ID=0, IDEN=0, LDDSTL=1, DSTACK=0, BUSY=0, ERR=0, wait counter=0.
REQ-037 Reset during LOAD SHALL return LDDSTL to 1 at that edge, with no DSTACK pulse.

Structure
REQ-038 The shared package SHALL hold the state enum type, the ADDR_W default and the TO_CYCLES default.
REQ-039 One sub-module, dst_wait_timer, SHALL implement the wait counter. Its ports: clear, count enable, terminal-count flag.
REQ-040 The top level SHALL contain only the state machine, the address register and the data register.

Verification
REQ-041 Nominal fetch: DSTADDR=20'h1A2B3, MGNT immediate, MRDY first WAIT cycle, MD=8'hC5 -> MADDR=20'h1A2B3, LDDSTL low in cycle n+4, ID=8'hC5 for n+3..n+5, DSTACK at n+6.
REQ-042 Delayed grant: MGNT after 5 REQ cycles and MRDY after 3 WAIT cycles, MD=8'h3C -> MREQ held continuously throughout, one LDDSTL pulse, ID=8'h3C, ERR=0.
REQ-043 Timeout: MRDY never asserted -> after 15 WAIT cycles ERR=1, MREQ=0, no LDDSTL pulse, one DSTACK. A following DSTREQ clears ERR.
REQ-044 Boundary: MRDY on the cycle the counter reaches 15 -> normal completion, ERR=0.
REQ-045 Busy collision: DSTREQ re-pulsed during WAIT and again during DONE -> exactly one fetch, one DSTACK, BUSY low one cycle after DSTACK.
REQ-046 Reset mid-op: RESET during LOAD -> next cycle all outputs at reset values, LDDSTL=1, no DSTACK; a subsequent fetch completes normally.

Source files
------------

// File: rtl/dst_fetch_pkg.sv
// rtl/dst_fetch_pkg.sv - shared types and defaults for the destination byte fetch
//
// Purpose : state encoding plus default address width and MRDY timeout.
// Ports   : none (package).

package dst_fetch_pkg;

  localparam int DST_ADDR_W    = 20;
  localparam int DST_TO_CYCLES = 15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRIVE = 3'd3,
    S_LOAD  = 3'd4,
    S_HOLD  = 3'd5,
    S_DONE  = 3'd6
  } dst_state_t;

endpackage

// File: rtl/dst_wait_timer.sv
// rtl/dst_wait_timer.sv - MRDY wait counter with terminal-count flag
//
// Purpose : counts WAIT cycles that pass without MRDY.
// Ports   : i_clk    system clock
//           i_rst    synchronous active-high reset
//           i_clear  hold count at zero (asserted outside WAIT)
//           i_en     count one cycle
//           o_tc     count has reached TO_CYCLES

module dst_wait_timer
  import dst_fetch_pkg::*;
#(
  parameter int TO_CYCLES = DST_TO_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int CNT_W = $clog2(TO_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at the terminal value so the flag can never wrap back to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(TO_CYCLES));

endmodule

// File: rtl/dst_fetch.sv
// rtl/dst_fetch.sv - fetches one destination byte from memory for the blitter
//
// Purpose : on DSTREQ, reads one byte over the memory bus, presents it on the
//           internal bus around an active-low load strobe, then acknowledges.
//           A read that waits too long for MRDY is aborted with a sticky ERR.
// Ports   : CLK, RESET           clock, synchronous active-high reset
//           DSTREQ, DSTADDR      fetch request and byte address
//           MREQ, MADDR          memory read request and address
//           MGNT, MRDY, MD       bus grant, data strobe, read data
//           ID, IDEN             internal bus byte and drive enable
//           LDDSTL               active-low destination register load
//           DSTACK, BUSY, ERR    completion pulse, busy, sticky timeout

module dst_fetch
  import dst_fetch_pkg::*;
#(
  parameter int ADDR_W    = DST_ADDR_W,
  parameter int TO_CYCLES = DST_TO_CYCLES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DSTREQ,
  input  logic [ADDR_W-1:0] DSTADDR,
  output logic              MREQ,
  output logic [ADDR_W-1:0] MADDR,
  input  logic              MGNT,
  input  logic              MRDY,
  input  logic [7:0]        MD,
  output logic [7:0]        ID,
  output logic              IDEN,
  output logic              LDDSTL,
  output logic              DSTACK,
  output logic              BUSY,
  output logic              ERR
);

  dst_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_mreq;
  logic              r_iden;
  logic              r_lddstl;
  logic              r_dstack;
  logic              r_busy;
  logic              r_err;

  logic              w_tmr_clear;
  logic              w_tmr_en;
  logic              w_tmr_tc;

  // The count restarts every time WAIT is entered because it is held clear
  // in every other state.
  assign w_tmr_clear = (r_state != S_WAIT);
  assign w_tmr_en    = (r_state == S_WAIT) && !MRDY;

  dst_wait_timer #(
    .TO_CYCLES (TO_CYCLES)
  ) u_wait_timer (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_clear (w_tmr_clear),
    .i_en    (w_tmr_en),
    .o_tc    (w_tmr_tc)
  );

  // Outputs are registered alongside the transition into the state that owns
  // them, so each output is already valid in the first cycle of that state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_mreq   <= 1'b0;
      r_iden   <= 1'b0;
      r_lddstl <= 1'b1;
      r_dstack <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_dstack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (DSTREQ) begin
            r_addr  <= DSTADDR;
            r_err   <= 1'b0;
            r_mreq  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (MGNT) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // MRDY is tested first so data arriving on the terminal cycle wins.
          if (MRDY) begin
            r_data  <= MD;
            r_mreq  <= 1'b0;
            r_iden  <= 1'b1;
            r_state <= S_DRIVE;
          end else if (w_tmr_tc) begin
            r_err    <= 1'b1;
            r_mreq   <= 1'b0;
            r_dstack <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DRIVE: begin
          r_lddstl <= 1'b0;
          r_state  <= S_LOAD;
        end
        S_LOAD: begin
          r_lddstl <= 1'b1;
          r_state  <= S_HOLD;
        end
        S_HOLD: begin
          r_iden   <= 1'b0;
          r_dstack <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign MREQ   = r_mreq;
  assign MADDR  = r_addr;
  assign IDEN   = r_iden;
  assign ID     = r_iden ? r_data : 8'h00;
  assign LDDSTL = r_lddstl;
  assign DSTACK = r_dstack;
  assign BUSY   = r_busy;
  assign ERR    = r_err;

endmodule

// File: tb/tb_dst_fetch.sv
// tb/tb_dst_fetch.sv - scoreboard bench for dst_fetch

module tb_dst_fetch;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DSTREQ = 1'b0;
  logic [19:0] DSTADDR = '0;
  logic        MREQ;
  logic [19:0] MADDR;
  logic        MGNT = 1'b0;
  logic        MRDY = 1'b0;
  logic [7:0]  MD = '0;
  logic [7:0]  ID;
  logic        IDEN;
  logic        LDDSTL;
  logic        DSTACK;
  logic        BUSY;
  logic        ERR;

  dst_fetch dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .DSTREQ  (DSTREQ),
    .DSTADDR (DSTADDR),
    .MREQ    (MREQ),
    .MADDR   (MADDR),
    .MGNT    (MGNT),
    .MRDY    (MRDY),
    .MD      (MD),
    .ID      (ID),
    .IDEN    (IDEN),
    .LDDSTL  (LDDSTL),
    .DSTACK  (DSTACK),
    .BUSY    (BUSY),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
    int          err;
    int          ld;
    int          ld_at;
    int          iden;
    int          bcyc;
    int          mcyc;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: accumulates what the DUT did during a fetch and scores it on DSTACK.
  int bcyc = 0, mcyc = 0, mruns = 0, ld = 0, ld_at = 0, idn = 0;
  int bad_addr = 0, bad_id = 0;
  logic prev_mreq = 1'b0;
  logic busy_chk = 1'b0;

  task automatic clr_mon();
    bcyc = 0; mcyc = 0; mruns = 0; ld = 0; ld_at = 0; idn = 0;
    bad_addr = 0; bad_id = 0; prev_mreq = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      clr_mon();
      busy_chk = 1'b0;
    end else begin
      if (BUSY) bcyc++;
      if (MREQ) begin
        mcyc++;
        if (!prev_mreq) mruns++;
        if (q.size() > 0 && MADDR !== q[0].addr) bad_addr++;
      end
      prev_mreq = MREQ;
      if (!LDDSTL) begin
        ld++;
        ld_at = bcyc;
      end
      if (IDEN) begin
        idn++;
        if (q.size() > 0 && ID !== q[0].data) bad_id++;
      end else if (ID !== 8'h00) begin
        bad_id++;
      end
      if (busy_chk) begin
        chk("busy_after_ack", BUSY, 0);
        busy_chk = 1'b0;
      end
      if (DSTACK) begin
        chk("ack_expected", q.size() != 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("maddr_ok", bad_addr, 0);
          chk("id_ok", bad_id, 0);
          chk("err", ERR, e.err);
          chk("ld_pulses", ld, e.ld);
          chk("ld_cycle", ld_at, e.ld_at);
          chk("iden_cycles", idn, e.iden);
          chk("ack_latency", bcyc, e.bcyc);
          chk("mreq_cycles", mcyc, e.mcyc);
          chk("mreq_runs", mruns, 1);
        end
        clr_mon();
        busy_chk = 1'b1;
      end else if (!BUSY) begin
        clr_mon();
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {MREQ, IDEN, LDDSTL, DSTACK, BUSY, ERR}, 6'b001000);
    chk({tag, "_maddr"}, MADDR, 0);
    chk({tag, "_id"}, ID, 0);
  endtask

  // g: REQ cycles before MGNT; r: WAIT cycles before MRDY (-1 = never).
  task automatic fetch(input logic [19:0] addr, input logic [7:0] data,
                       input int g, input int r, input bit collide,
                       input int e_err, input int e_ld_at, input int e_bcyc, input int e_mcyc);
    exp_t e;
    int t;
    e.addr = addr; e.data = data; e.err = e_err;
    e.ld = (e_ld_at != 0) ? 1 : 0; e.ld_at = e_ld_at;
    e.iden = (e_ld_at != 0) ? 3 : 0; e.bcyc = e_bcyc; e.mcyc = e_mcyc;
    @(posedge CLK) #1;
    DSTREQ = 1'b1; DSTADDR = addr;
    q.push_back(e);
    @(posedge CLK) #1;
    DSTREQ = 1'b0; DSTADDR = ~addr;
    for (int k = 0; k <= g; k++) begin
      MGNT = (k == g);
      MRDY = (k != g);          // stray strobes outside WAIT must be ignored
      MD   = 8'hEE;
      @(posedge CLK) #1;
    end
    MGNT = 1'b0; MRDY = 1'b0;
    if (r >= 0) begin
      for (int j = 0; j <= r; j++) begin
        MRDY   = (j == r);
        MD     = (j == r) ? data : ~data;
        DSTREQ = collide && (j == 0);
        @(posedge CLK) #1;
      end
      MRDY = 1'b0; DSTREQ = 1'b0; MD = 8'h00;
      if (collide) begin
        repeat (3) @(posedge CLK) #1;
        DSTREQ = 1'b1;
        @(posedge CLK) #1;
        DSTREQ = 1'b0;
      end
    end
    t = 0;
    while (BUSY && t < 60) begin
      @(posedge CLK) #1;
      t++;
    end
    chk("busy_drops", t < 60, 1);
    repeat (2) @(posedge CLK) #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_vals("reset");
    RESET = 1'b0;

    // nominal: ack at n+6, load at n+4
    fetch(20'h1A2B3, 8'hC5, 0, 0, 1'b0, 0, 4, 6, 2);
    // delayed grant and data
    fetch(20'h0F00D, 8'h3C, 5, 3, 1'b0, 0, 12, 14, 10);
    // timeout: 16 WAIT cycles, no load
    fetch(20'hFFFFF, 8'h5A, 0, -1, 1'b0, 1, 0, 18, 17);
    chk("err_sticky", ERR, 1);
    chk("idle_after_timeout", {MREQ, IDEN, LDDSTL, BUSY}, 4'b0010);
    // MRDY on the terminal-count cycle still completes; ERR cleared by accept
    fetch(20'h80001, 8'hA5, 0, 15, 1'b0, 0, 19, 21, 17);
    chk("err_cleared", ERR, 0);
    // DSTREQ repeated in WAIT and DONE: only one fetch
    fetch(20'h12345, 8'h96, 0, 0, 1'b1, 0, 4, 6, 2);
    chk("no_second_fetch", {BUSY, MREQ}, 2'b00);
    chk("queue_drained", q.size(), 0);

    // reset while LDDSTL is low
    @(posedge CLK) #1;
    DSTREQ = 1'b1; DSTADDR = 20'h55555;
    @(posedge CLK) #1;
    DSTREQ = 1'b0; MGNT = 1'b1;
    @(posedge CLK) #1;
    MGNT = 1'b0; MRDY = 1'b1; MD = 8'h11;
    @(posedge CLK) #1;
    MRDY = 1'b0;
    @(posedge CLK) #1;
    chk("in_load", LDDSTL, 0);
    RESET = 1'b1;
    @(posedge CLK) #1;
    RESET = 1'b0;
    chk_reset_vals("midop");
    repeat (4) @(posedge CLK) #1;
    chk("midop_idle", {BUSY, DSTACK}, 2'b00);

    fetch(20'h0ABCD, 8'h7E, 0, 0, 1'b0, 0, 4, 6, 2);
    repeat (3) @(posedge CLK) #1;
    chk("final_queue", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
